// File: rtl/pulse_train_gen.sv
`default_nettype none
// ============================================================================
//  Module      : pulse_train_gen
//  Description : Trigger-started pulse burst generator. After a programmable
//                delay it emits pulses with programmable high/low time and
//                count. Supports one-shot, retriggerable and continuous modes.
//  Revision    : 1.0  initial release
// ============================================================================
module pulse_train_gen #(
   parameter int WIDTH = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             trigger,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] delay,
   input  logic [WIDTH-1:0] high_len,
   input  logic [WIDTH-1:0] low_len,
   input  logic [WIDTH-1:0] count,
   output logic             signal,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] pulse_idx
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DELAY = 2'd1,
      ST_HIGH  = 2'd2,
      ST_LOW   = 2'd3
   } state_t;

   localparam logic [1:0]       MODE_RETRIG = 2'd1;
   localparam logic [1:0]       MODE_CONT   = 2'd2;
   localparam logic [WIDTH-1:0] CNT_ONE     = WIDTH'(1);

   state_t           r_state,     w_state;
   logic [WIDTH-1:0] r_cnt,       w_cnt;
   logic [WIDTH-1:0] r_high,      w_high;
   logic [WIDTH-1:0] r_low,       w_low;
   logic [WIDTH-1:0] r_remaining, w_remaining;
   logic [WIDTH-1:0] r_idx,       w_idx;
   logic [1:0]       r_mode,      w_mode;
   logic             r_signal,    w_signal;
   logic             r_done,      w_done;
   logic             r_trig_q;

   logic             w_rise;
   logic             w_load;
   logic [WIDTH-1:0] w_high_in;
   logic [WIDTH-1:0] w_low_in;
   logic [WIDTH-1:0] w_count_in;

   // Zero lengths/counts are promoted to one; a rise loads a burst from idle,
   // or restarts a running burst when the latched mode is retriggerable.
   always_comb begin
      w_high_in  = (high_len == '0) ? CNT_ONE : high_len;
      w_low_in   = (low_len  == '0) ? CNT_ONE : low_len;
      w_count_in = (count    == '0) ? CNT_ONE : count;
      w_rise     = trigger & ~r_trig_q;
      w_load     = w_rise & ((r_state == ST_IDLE) | (r_mode == MODE_RETRIG));
   end

   // Next-state and next-output logic; counters count down to one.
   always_comb begin
      w_state     = r_state;
      w_cnt       = r_cnt;
      w_high      = r_high;
      w_low       = r_low;
      w_remaining = r_remaining;
      w_idx       = r_idx;
      w_mode      = r_mode;
      w_signal    = r_signal;
      w_done      = 1'b0;
      if (w_load) begin
         w_mode      = mode;
         w_high      = w_high_in;
         w_low       = w_low_in;
         w_remaining = w_count_in;
         w_idx       = '0;
         if (delay != '0) begin
            w_state  = ST_DELAY;
            w_cnt    = delay;
            w_signal = 1'b0;
         end else begin
            w_state  = ST_HIGH;
            w_cnt    = w_high_in;
            w_signal = 1'b1;
         end
      end else begin
         case (r_state)
            ST_DELAY: begin
               if (r_cnt <= CNT_ONE) begin
                  w_state  = ST_HIGH;
                  w_cnt    = r_high;
                  w_signal = 1'b1;
               end else begin
                  w_cnt = r_cnt - CNT_ONE;
               end
            end
            ST_HIGH: begin
               if (r_cnt <= CNT_ONE) begin
                  w_state  = ST_LOW;
                  w_cnt    = r_low;
                  w_signal = 1'b0;
               end else begin
                  w_cnt = r_cnt - CNT_ONE;
               end
            end
            ST_LOW: begin
               if (r_cnt <= CNT_ONE) begin
                  if ((r_mode == MODE_CONT) ? trigger : (r_remaining > CNT_ONE)) begin
                     w_state  = ST_HIGH;
                     w_cnt    = r_high;
                     w_signal = 1'b1;
                     w_idx    = r_idx + CNT_ONE;
                     if (r_mode != MODE_CONT) begin
                        w_remaining = r_remaining - CNT_ONE;
                     end
                  end else begin
                     w_state  = ST_IDLE;
                     w_cnt    = '0;
                     w_signal = 1'b0;
                     w_done   = 1'b1;
                  end
               end else begin
                  w_cnt = r_cnt - CNT_ONE;
               end
            end
            default: begin
               w_state = ST_IDLE;
            end
         endcase
      end
   end

   // State and output registers; trig_q resets high so a held trigger needs a fresh edge.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_high      <= '0;
         r_low       <= '0;
         r_remaining <= '0;
         r_idx       <= '0;
         r_mode      <= 2'd0;
         r_signal    <= 1'b0;
         r_done      <= 1'b0;
         r_trig_q    <= 1'b1;
      end else begin
         r_state     <= w_state;
         r_cnt       <= w_cnt;
         r_high      <= w_high;
         r_low       <= w_low;
         r_remaining <= w_remaining;
         r_idx       <= w_idx;
         r_mode      <= w_mode;
         r_signal    <= w_signal;
         r_done      <= w_done;
         r_trig_q    <= trigger;
      end
   end

   assign signal    = r_signal;
   assign busy      = (r_state != ST_IDLE);
   assign done      = r_done;
   assign pulse_idx = r_idx;

endmodule
`default_nettype wire

// File: tb/tb_pulse_train_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pulse_train_gen
//  Description : Directed-vector bench for pulse_train_gen with a queue-based
//                scoreboard checked once per cycle by an independent monitor.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pulse_train_gen;

   localparam int W = 8;

   logic         clock    = 1'b0;
   logic         reset    = 1'b1;
   logic         trigger  = 1'b1;
   logic [1:0]   mode     = 2'd0;
   logic [W-1:0] delay    = '0;
   logic [W-1:0] high_len = '0;
   logic [W-1:0] low_len  = '0;
   logic [W-1:0] count    = '0;
   logic         signal;
   logic         busy;
   logic         done;
   logic [W-1:0] pulse_idx;

   pulse_train_gen #(.WIDTH(W)) dut (
      .clock     (clock),
      .reset     (reset),
      .trigger   (trigger),
      .mode      (mode),
      .delay     (delay),
      .high_len  (high_len),
      .low_len   (low_len),
      .count     (count),
      .signal    (signal),
      .busy      (busy),
      .done      (done),
      .pulse_idx (pulse_idx)
   );

   always #5 clock = ~clock;

   typedef struct {
      string        name;
      int           t;
      logic         sig;
      logic         bsy;
      logic         dn;
      logic [W-1:0] idx;
      bit           idx_care;
   } exp_t;

   exp_t q[$];
   int   vectors     = 0;
   int   miscompares = 0;

   // Monitor: one expectation per cycle, checked mid-cycle.
   always @(negedge clock) begin
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         vectors++;
         if (signal !== e.sig || busy !== e.bsy || done !== e.dn ||
             (e.idx_care && pulse_idx !== e.idx)) begin
            miscompares++;
            $display("FAIL %s t=%0d: got sig=%b busy=%b done=%b idx=%0d, want sig=%b busy=%b done=%b idx=%0d%s",
                     e.name, e.t, signal, busy, done, pulse_idx,
                     e.sig, e.bsy, e.dn, e.idx, e.idx_care ? "" : "(any)");
         end
      end
   end

   // Advance one edge, then queue the outputs expected after that edge.
   task automatic tick(input string name, input int t, input logic s, input logic b,
                       input logic d, input logic [W-1:0] i, input bit care);
      exp_t e;
      @(posedge clock);
      #2;
      e.name = name; e.t = t; e.sig = s; e.bsy = b; e.dn = d; e.idx = i; e.idx_care = care;
      q.push_back(e);
   endtask

   // Expected outputs t edges after E0 for a non-continuous burst with
   // effective delay D, high H, low L and count N.
   task automatic burst_step(input string name, input int t, input int D, input int H,
                             input int L, input int N);
      int p;
      int tend;
      p    = H + L;
      tend = D + N * p;
      if (t < D)
         tick(name, t, 1'b0, 1'b1, 1'b0, '0, 1'b1);
      else if (t < tend)
         tick(name, t, ((t - D) % p) < H, 1'b1, 1'b0, W'((t - D) / p), 1'b1);
      else if (t == tend)
         tick(name, t, 1'b0, 1'b0, 1'b1, '0, 1'b0);
      else
         tick(name, t, 1'b0, 1'b0, 1'b0, '0, 1'b0);
   endtask

   task automatic idle(input string name);
      tick(name, 0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
   endtask

   initial begin
      // Reset with trigger held high, then release: no burst may start.
      for (int t = 0; t < 3; t++) tick("reset", t, 1'b0, 1'b0, 1'b0, '0, 1'b1);
      reset = 1'b0;
      for (int t = 0; t < 3; t++) tick("held_trigger", t, 1'b0, 1'b0, 1'b0, '0, 1'b1);

      // One-shot D=2 H=3 L=2 N=2; inputs changed mid-burst must be ignored.
      trigger = 1'b0;
      idle("pre_oneshot");
      mode = 2'd0; delay = 8'd2; high_len = 8'd3; low_len = 8'd2; count = 8'd2;
      trigger = 1'b1;
      for (int t = 0; t <= 14; t++) begin
         burst_step("oneshot", t, 2, 3, 2, 2);
         if (t == 3) begin
            high_len = 8'd9; delay = 8'd5; count = 8'd7;
         end
      end

      // Zero substitution; a rise while busy in mode 0 is ignored.
      trigger = 1'b0;
      idle("pre_zero");
      mode = 2'd0; delay = '0; high_len = '0; low_len = '0; count = '0;
      trigger = 1'b1;
      for (int t = 0; t <= 4; t++) begin
         burst_step("zero_sub", t, 0, 1, 1, 1);
         if (t == 0) trigger = 1'b0;
         if (t == 1) trigger = 1'b1;
      end

      // A rise sampled in the done cycle starts a new burst; mode 3 acts as one-shot.
      trigger = 1'b0;
      idle("pre_donerise");
      mode = 2'd3; delay = '0; high_len = 8'd1; low_len = 8'd1; count = 8'd1;
      trigger = 1'b1;
      for (int t = 0; t <= 2; t++) begin
         burst_step("done_rise_a", t, 0, 1, 1, 1);
         if (t == 1) trigger = 1'b0;
         if (t == 2) trigger = 1'b1;
      end
      for (int t = 0; t <= 3; t++) burst_step("done_rise_b", t, 0, 1, 1, 1);

      // Retrigger mode 1, D=4 H=2 L=2 N=3, second rise at E0+5.
      trigger = 1'b0;
      idle("pre_retrig");
      mode = 2'd1; delay = 8'd4; high_len = 8'd2; low_len = 8'd2; count = 8'd3;
      trigger = 1'b1;
      for (int t = 0; t <= 4; t++) begin
         burst_step("retrig_a", t, 4, 2, 2, 3);
         if (t == 3) trigger = 1'b0;
         if (t == 4) trigger = 1'b1;
      end
      for (int t = 0; t <= 17; t++) burst_step("retrig_b", t, 4, 2, 2, 3);

      // Continuous mode 2, D=1 H=1 L=1, trigger sampled high on 10 edges.
      trigger = 1'b0;
      idle("pre_cont");
      mode = 2'd2; delay = 8'd1; high_len = 8'd1; low_len = 8'd1; count = '0;
      trigger = 1'b1;
      for (int t = 0; t <= 12; t++) begin
         if (t == 0)
            tick("continuous", t, 1'b0, 1'b1, 1'b0, '0, 1'b1);
         else if (t <= 10)
            tick("continuous", t, (t % 2) == 1, 1'b1, 1'b0, W'((t - 1) / 2), 1'b1);
         else if (t == 11)
            tick("continuous", t, 1'b0, 1'b0, 1'b1, '0, 1'b0);
         else
            tick("continuous", t, 1'b0, 1'b0, 1'b0, '0, 1'b0);
         if (t == 9) trigger = 1'b0;
      end

      // Reset during HIGH aborts at once; held trigger does not restart afterwards.
      trigger = 1'b0;
      idle("pre_midreset");
      mode = 2'd0; delay = '0; high_len = 8'd5; low_len = 8'd1; count = 8'd1;
      trigger = 1'b1;
      for (int t = 0; t <= 2; t++) burst_step("mid_reset_run", t, 0, 5, 1, 1);
      reset = 1'b1;
      tick("mid_reset", 0, 1'b0, 1'b0, 1'b0, '0, 1'b1);
      reset = 1'b0;
      for (int t = 0; t < 3; t++) tick("after_reset", t, 1'b0, 1'b0, 1'b0, '0, 1'b1);

      @(negedge clock);
      #1;
      if (q.size() != 0) begin
         miscompares++;
         $display("FAIL scoreboard_drain: got %0d pending, want 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/pulse_train_gen.md
# pulse_train_gen

- Synthesizable, parametrised pulse/trigger generator.
- On a trigger edge it waits a programmable delay, then emits a burst of pulses with programmable high time, low time and pulse count.
- Supports one-shot, retriggerable and continuous modes, and reports status through `busy`, `done` and a pulse index.
- Sits beside the free-running test clock; provides clock-synchronous stimulus and strobe pulses to the rest of the design.

## Interface

Parameters:
- `WIDTH`, default 8: width of delay, high, low and count fields, and of the internal counters.

Ports:
- `clock`, input, 1: the single clock; all logic updates on its rising edge.
- `reset`, input, 1: synchronous, active-high.
- `trigger`, input, 1: start request. Rising edge is detected internally; the level is also used in continuous mode.
- `mode`, input, 2: 0 = one-shot, 1 = retriggerable, 2 = continuous, 3 = treated as one-shot.
- `delay`, input, WIDTH: cycles from trigger detection to the first high.
- `high_len`, input, WIDTH: high cycles per pulse. 0 is treated as 1.
- `low_len`, input, WIDTH: low cycles per pulse. 0 is treated as 1.
- `count`, input, WIDTH: pulses per burst. 0 is treated as 1. Ignored in continuous mode.
- `signal`, output, 1: registered pulse output.
- `busy`, output, 1: high while any state other than IDLE is active.
- `done`, output, 1: one-cycle strobe when a burst completes normally.
- `pulse_idx`, output, WIDTH: index of the current pulse, starting at 0. Wraps modulo 2^WIDTH in continuous mode.

## Operation

- States: IDLE, DELAY, HIGH, LOW.
- Edge detect: `trig_q` is a registered copy of `trigger`. `rise = trigger & ~trig_q`.
- IDLE, `rise` sampled at edge E0:
  - latch `mode`, `delay`, `high_len`, `low_len`, `count` (after zero-substitution) into internal registers;
  - go to DELAY if delay > 0, else go directly to HIGH.
  - Inputs changing mid-burst have no effect.
- DELAY lasts `delay` cycles, then HIGH.
- HIGH lasts H cycles with `signal` = 1, then LOW.
- LOW lasts L cycles with `signal` = 0. At its end:
  - if pulses emitted < N, return to HIGH and increment `pulse_idx`;
  - otherwise go to IDLE and pulse `done`.
- One-shot (modes 0 and 3): `rise` while busy is ignored.
- Retriggerable (mode 1): `rise` in DELAY, HIGH or LOW restarts exactly as from IDLE:
  - parameters are relatched and `pulse_idx` returns to 0;
  - `signal` drops to 0 if the restart enters DELAY;
  - no `done` is issued for the aborted burst.
- Continuous (mode 2): N is ignored.
  - At each LOW end: if `trigger` is sampled 1, go to HIGH; else go to IDLE with `done`.
  - A trigger that drops during DELAY or HIGH lets the current pulse, including its LOW phase, complete.
- Counters are WIDTH bits and count down to 1. No counter ever underflows.

## Timing

- Reset values: `signal` = 0, `busy` = 0, `done` = 0, `pulse_idx` = 0, state = IDLE, all counters 0.
- `trig_q` resets to 1, so a trigger held high through reset release does not start a burst; a fresh 0→1 is required.
- Reset mid-burst aborts immediately on that edge: outputs go to their reset values, no `done`.
- Edge numbering is relative to E0, the edge that samples `rise`:
  - `busy` = 1 after E0;
  - `signal` first high after edge E0+D, for H cycles;
  - pulse k (0-based) is high after edges E0+D+k(H+L) through E0+D+k(H+L)+H−1.
- `done` = 1 and `busy` = 0 after edge E0+D+N(H+L), for exactly one cycle.
- A `rise` sampled in the same cycle that `done` is high (IDLE reached) starts a new burst on that edge.
- Simultaneous `reset` and `rise`: reset wins.

## Test plan

- Reset behaviour: hold `trigger` = 1 and deassert `reset` → no burst starts, all outputs stay 0. Then drop `trigger` and raise it again → a burst starts.
- One-shot: D=2, H=3, L=2, N=2 → `signal` high after E0+2..E0+4 and E0+7..E0+9; `pulse_idx` = 1 from E0+7; `done` after E0+12; `busy` high for exactly 12 cycles.
- Zero substitution: D=0, H=0, L=0, N=0 → `signal` high only after E0, low after E0+1, `done` after E0+2. A second `rise` while busy in mode 0 is ignored.
- Retrigger: mode 1, D=4, H=2, L=2, N=3, second `rise` at E0+5 → `signal` falls, then rises at E0+9; no `done` before E0+21.
- Continuous: mode 2, D=1, H=1, L=1, `trigger` high for 10 cycles → alternating `signal`. `done` follows the first LOW end after `trigger` is sampled low; `pulse_idx` counts up.
- Mid-burst reset: assert `reset` during HIGH → `signal`, `busy`, `done` and `pulse_idx` all 0 on the next edge.
